// File: rtl/rom_router_pkg.sv
// Shared types and the per-port lane mapping helper for the ROM download router.
package rom_router_pkg;

    localparam int MAX_PORTS = 4;
    localparam int MAX_AW    = 32;

    typedef enum logic {IDLE, WAIT} state_t;

    typedef struct packed {
        logic [MAX_AW-1:0]    addr;
        logic [7:0]           data;
        logic [MAX_PORTS-1:0] hit;
        logic                 valid;
    } skid_t;

    typedef struct packed {
        logic [MAX_AW-1:0] a;
        logic [1:0]        ds;
    } lane_t;

    // k = 0 packs byte pairs into words; k >= 1 pulls bit k out as the lane select.
    function automatic lane_t lane_map(input logic [MAX_AW-1:0] off, input logic [4:0] k);
        lane_t r;
        if (k == 5'd0) begin
            r.a  = off >> 1;
            r.ds = {off[0], ~off[0]};
        end else begin
            r.a  = ((off >> (k + 5'd1)) << k) | (off & ((32'd1 << k) - 32'd1));
            r.ds = {~off[k], off[k]};
        end
        return r;
    endfunction

endpackage

// File: rtl/rom_router_map.sv
// Per-port address window hit test and 8->16-bit lane mapping.
module rom_router_map
    import rom_router_pkg::*;
#(
    parameter int               IO_AW = 25,
    parameter int               SD_AW = 23,
    parameter logic [IO_AW-1:0] BASE  = '0,
    parameter logic [IO_AW-1:0] LIMIT = '1,
    parameter logic [4:0]       ILV   = 5'd0
) (
    input  logic [IO_AW-1:0]  hit_addr,
    input  logic [MAX_AW-1:0] map_addr,
    output logic              hit,
    output logic [SD_AW-1:0]  a,
    output logic [1:0]        ds
);

    logic [IO_AW-1:0] span_off;
    lane_t            lane;

    // Single unsigned compare against the window span; assumes BASE <= LIMIT.
    assign span_off = hit_addr - BASE;
    assign hit      = (span_off <= IO_AW'(LIMIT - BASE));

    assign lane = lane_map(map_addr - MAX_AW'(BASE), ILV);
    assign a    = lane.a[SD_AW-1:0];
    assign ds   = lane.ds;

endmodule

// File: rtl/rom_download_router.sv
// Routes ioctl download bytes to SDRAM write ports over toggle req/ack, with a one-entry skid.
// Optional running checksum port enabled by defining ROM_ROUTER_CHECKSUM_EN.
module rom_download_router
    import rom_router_pkg::*;
#(
    parameter int                           NUM_PORTS  = 2,
    parameter int                           IO_AW      = 25,
    parameter int                           SD_AW      = 23,
    parameter logic [7:0]                   ROM_INDEX  = 8'h00,
    parameter logic [MAX_PORTS*IO_AW-1:0]   PORT_BASE  = '0,
    parameter logic [MAX_PORTS*IO_AW-1:0]   PORT_LIMIT = '1,
    parameter logic [MAX_PORTS*5-1:0]       PORT_ILV   = '0,
    parameter int                           RESET_HOLD = 16
) (
    input  logic                       clk_sys,
    input  logic                       reset_n,
    input  logic                       ioctl_download,
    input  logic [7:0]                 ioctl_index,
    input  logic                       ioctl_wr,
    input  logic [IO_AW-1:0]           ioctl_addr,
    input  logic [7:0]                 ioctl_dout,
    output logic [NUM_PORTS-1:0]       port_req,
    input  logic [NUM_PORTS-1:0]       port_ack,
    output logic [NUM_PORTS*SD_AW-1:0] port_a,
    output logic [NUM_PORTS*2-1:0]     port_ds,
    output logic [15:0]                port_d,
    output logic                       port_we,
    input  logic                       rst_req,
    output logic                       rom_loaded,
    output logic                       reset_out,
    output logic                       overflow
`ifdef ROM_ROUTER_CHECKSUM_EN
    ,
    output logic [15:0]                checksum
`endif
);

    state_t                state;
    skid_t                 skid;
    logic                  wr_last;
    logic                  dl_last;
    logic                  end_pend;
    logic [NUM_PORTS-1:0]  pend;
    logic [15:0]           hold_cnt;

    logic                  accept;
    logic                  done;
    logic                  from_skid;
    logic                  issue;
    logic                  wait_accept;
    logic                  skid_load;
    logic                  skid_drop;
    logic                  dl_fall;
    logic [NUM_PORTS-1:0]  hit;
    logic [MAX_PORTS-1:0]  new_hit4;
    logic [MAX_PORTS-1:0]  mask4;
    logic [NUM_PORTS-1:0]  issue_mask;
    logic [MAX_AW-1:0]     map_addr;
    logic [7:0]            iss_data;
    logic [SD_AW-1:0]      map_a  [NUM_PORTS];
    logic [1:0]            map_ds [NUM_PORTS];

    assign accept    = ioctl_wr & ~wr_last & ioctl_download & (ioctl_index == ROM_INDEX);
    assign done      = ((port_ack ^ port_req) & pend) == '0;
    assign from_skid = (state == WAIT) & skid.valid;
    assign new_hit4  = MAX_PORTS'(hit);
    assign mask4     = from_skid ? skid.hit : new_hit4;
    assign issue_mask = mask4[NUM_PORTS-1:0];
    assign map_addr  = from_skid ? skid.addr : MAX_AW'(ioctl_addr);
    assign iss_data  = from_skid ? skid.data : ioctl_dout;
    assign dl_fall   = ~ioctl_download & dl_last;

    // Hit test always looks at the incoming byte; lane mapping follows whatever is being issued.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_map
        rom_router_map #(
            .IO_AW (IO_AW),
            .SD_AW (SD_AW),
            .BASE  (PORT_BASE[p*IO_AW +: IO_AW]),
            .LIMIT (PORT_LIMIT[p*IO_AW +: IO_AW]),
            .ILV   (PORT_ILV[p*5 +: 5])
        ) u_map (
            .hit_addr (ioctl_addr),
            .map_addr (map_addr),
            .hit      (hit[p]),
            .a        (map_a[p]),
            .ds       (map_ds[p])
        );
    end

    always_comb begin
        issue = 1'b0;
        case (state)
            IDLE:    issue = accept & (|mask4);
            WAIT:    issue = done & (skid.valid | (accept & (|mask4)));
            default: issue = 1'b0;
        endcase
    end

    // When the skid drains on completion, a simultaneous new byte takes its place.
    assign wait_accept = (state == WAIT) & accept & (|new_hit4);
    assign skid_load   = wait_accept & (done ? skid.valid : ~skid.valid);
    assign skid_drop   = wait_accept & ~done & skid.valid;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            skid       <= '0;
            wr_last    <= 1'b0;
            dl_last    <= 1'b0;
            end_pend   <= 1'b0;
            pend       <= '0;
            port_req   <= '0;
            port_a     <= '0;
            port_ds    <= '0;
            port_d     <= '0;
            port_we    <= 1'b0;
            rom_loaded <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            wr_last <= ioctl_wr;
            dl_last <= ioctl_download;
            port_we <= ioctl_download;

            if (issue) begin
                state    <= WAIT;
                port_req <= port_req ^ issue_mask;
                pend     <= issue_mask;
                port_d   <= {iss_data, iss_data};
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (issue_mask[p]) begin
                        port_a[p*SD_AW +: SD_AW] <= map_a[p];
                        port_ds[p*2 +: 2]        <= map_ds[p];
                    end
                end
            end else if (state == WAIT && done) begin
                state <= IDLE;
            end

            if (skid_load) begin
                skid <= '{addr: MAX_AW'(ioctl_addr), data: ioctl_dout, hit: new_hit4, valid: 1'b1};
            end else if (issue && from_skid) begin
                skid.valid <= 1'b0;
            end

            if (skid_drop) begin
                overflow <= 1'b1;
            end

            if (dl_fall || end_pend) begin
                if (state == IDLE) begin
                    rom_loaded <= 1'b1;
                    end_pend   <= 1'b0;
                end else begin
                    end_pend <= 1'b1;
                end
            end
        end
    end

    // reset_out is registered, so it drops RESET_HOLD+1 cycles after rom_loaded rises.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt  <= 16'(RESET_HOLD);
            reset_out <= 1'b1;
        end else begin
            if (rst_req || !rom_loaded) begin
                hold_cnt <= 16'(RESET_HOLD);
            end else if (hold_cnt != 16'd0) begin
                hold_cnt <= hold_cnt - 16'd1;
            end
            reset_out <= rst_req | ~rom_loaded | (hold_cnt != 16'd0);
        end
    end

`ifdef ROM_ROUTER_CHECKSUM_EN
    logic dl_rise;
    assign dl_rise = ioctl_download & ~dl_last;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            checksum <= 16'h0000;
        end else if (accept) begin
            checksum <= (dl_rise ? 16'h0000 : checksum) + 16'(ioctl_dout);
        end else if (dl_rise) begin
            checksum <= 16'h0000;
        end
    end
`endif

endmodule

// File: tb/tb_rom_download_router.sv
// Directed plus randomized bench for rom_download_router against an arithmetic window/lane model.
// Checksum checks are compiled in when ROM_ROUTER_CHECKSUM_EN is defined.
module tb_rom_download_router;

    localparam int NP    = 2;
    localparam int IO_AW = 25;
    localparam int SD_AW = 23;

    logic                  clk_sys = 1'b0;
    logic                  reset_n;
    logic                  ioctl_download;
    logic [7:0]            ioctl_index;
    logic                  ioctl_wr;
    logic [IO_AW-1:0]      ioctl_addr;
    logic [7:0]            ioctl_dout;
    logic [NP-1:0]         port_req;
    logic [NP-1:0]         port_ack;
    logic [NP*SD_AW-1:0]   port_a;
    logic [NP*2-1:0]       port_ds;
    logic [15:0]           port_d;
    logic                  port_we;
    logic                  rst_req;
    logic                  rom_loaded;
    logic                  reset_out;
    logic                  overflow;
`ifdef ROM_ROUTER_CHECKSUM_EN
    logic [15:0]           checksum;
`endif

    int tests    = 0;
    int failures = 0;
    logic [NP-1:0] exp_req;

    always #5 clk_sys = ~clk_sys;

    rom_download_router #(
        .NUM_PORTS  (NP),
        .IO_AW      (IO_AW),
        .SD_AW      (SD_AW),
        .ROM_INDEX  (8'h00),
        .PORT_BASE  ({25'h0, 25'h0, 25'h000C000, 25'h0}),
        .PORT_LIMIT ({25'h1FFFFFF, 25'h1FFFFFF, 25'h001BFFF, 25'h000FFFF}),
        .PORT_ILV   ({5'd0, 5'd0, 5'd14, 5'd0}),
        .RESET_HOLD (16)
    ) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .port_req       (port_req),
        .port_ack       (port_ack),
        .port_a         (port_a),
        .port_ds        (port_ds),
        .port_d         (port_d),
        .port_we        (port_we),
        .rst_req        (rst_req),
        .rom_loaded     (rom_loaded),
        .reset_out      (reset_out),
        .overflow       (overflow)
`ifdef ROM_ROUTER_CHECKSUM_EN
        ,
        .checksum       (checksum)
`endif
    );

    // Window table and mapping rules evaluated with plain arithmetic.
    function automatic void model(input int p, input int unsigned addr,
                                  output bit hit, output int unsigned a, output logic [1:0] ds);
        int unsigned base, lim, k, off;
        base = (p == 0) ? 32'h0 : 32'hC000;
        lim  = (p == 0) ? 32'hFFFF : 32'h1BFFF;
        k    = (p == 0) ? 0 : 14;
        hit  = (addr >= base) && (addr <= lim);
        off  = addr - base;
        if (k == 0) begin
            a  = off / 2;
            ds = (off % 2 == 1) ? 2'b10 : 2'b01;
        end else begin
            a  = (off / (1 << (k + 1))) * (1 << k) + off % (1 << k);
            ds = (((off >> k) % 2) == 1) ? 2'b01 : 2'b10;
        end
        a = a % (1 << SD_AW);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One strobe: high for one sampled cycle; returns just after the issuing edge.
    task automatic applyStimulus(input int unsigned addr, input logic [7:0] data);
        @(negedge clk_sys);
        ioctl_addr = IO_AW'(addr);
        ioctl_dout = data;
        ioctl_wr   = 1'b1;
        @(negedge clk_sys);
        ioctl_wr   = 1'b0;
    endtask

    task automatic expectIssue(input string tag, input int unsigned addr, input logic [7:0] data,
                               output logic [NP-1:0] mask);
        bit hit;
        int unsigned a;
        logic [1:0] ds;
        mask = '0;
        for (int p = 0; p < NP; p++) begin
            model(p, addr, hit, a, ds);
            if (hit) begin
                mask[p] = 1'b1;
                checkOutput({tag, "_a"}, port_a[p*SD_AW +: SD_AW], 64'(a));
                checkOutput({tag, "_ds"}, port_ds[p*2 +: 2], 64'(ds));
            end
        end
        exp_req = exp_req ^ mask;
        checkOutput({tag, "_req"}, port_req, exp_req);
        if (mask != '0) checkOutput({tag, "_d"}, port_d, {data, data});
    endtask

    task automatic ackPorts(input logic [NP-1:0] mask);
        for (int p = 0; p < NP; p++)
            if (mask[p]) port_ack[p] = exp_req[p];
    endtask

    initial begin
        logic [NP-1:0] m, m2;
        int unsigned addr;
        logic [7:0] data;
        int cnt;

        reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'h00; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0; port_ack = '0; rst_req = 1'b0; exp_req = '0;
        repeat (2) @(negedge clk_sys);
        checkOutput("rst_req", port_req, 0);
        checkOutput("rst_a", port_a, 0);
        checkOutput("rst_ds", port_ds, 0);
        checkOutput("rst_d", port_d, 0);
        checkOutput("rst_we", port_we, 0);
        checkOutput("rst_loaded", rom_loaded, 0);
        checkOutput("rst_reset_out", reset_out, 1);
        checkOutput("rst_overflow", overflow, 0);
        reset_n = 1'b1;
        ioctl_download = 1'b1;
        repeat (2) @(negedge clk_sys);
        checkOutput("we_high", port_we, 1);

        // Linear mapping on port 0 only.
        applyStimulus(32'h0003, 8'h5A);
        expectIssue("linear", 32'h0003, 8'h5A, m);
        checkOutput("linear_mask", m, 2'b01);
        ackPorts(m); @(negedge clk_sys);

        // Interleave mapping on port 1, and an overlapping address hitting both.
        applyStimulus(32'h10005, 8'h11);
        expectIssue("ilv_hi", 32'h10005, 8'h11, m);
        checkOutput("ilv_hi_ds", port_ds[3:2], 2'b01);
        ackPorts(m); @(negedge clk_sys);

        applyStimulus(32'hC005, 8'h22);
        expectIssue("multi", 32'hC005, 8'h22, m);
        checkOutput("multi_mask", m, 2'b11);
        ackPorts(2'b01); @(negedge clk_sys);
        applyStimulus(32'h0010, 8'h33);
        checkOutput("multi_wait_req", port_req, exp_req);
        repeat (3) @(negedge clk_sys);
        checkOutput("multi_hold_req", port_req, exp_req);
        ackPorts(2'b10); @(negedge clk_sys);
        expectIssue("multi_skid", 32'h0010, 8'h33, m);
        ackPorts(m); @(negedge clk_sys);

        // Index filter: other indices are ignored entirely.
        ioctl_index = 8'h01;
        applyStimulus(32'h0000, 8'h44);
        checkOutput("index_filter", port_req, exp_req);
        ioctl_index = 8'h00;

        // Backpressure: one skid entry, then overflow.
        applyStimulus(32'h0100, 8'hA1);
        expectIssue("bp_a", 32'h0100, 8'hA1, m);
        applyStimulus(32'hC00A, 8'hB2);
        checkOutput("bp_b_req", port_req, exp_req);
        checkOutput("bp_b_ovf", overflow, 0);
        applyStimulus(32'h0104, 8'hC3);
        checkOutput("bp_c_ovf", overflow, 1);
        repeat (36) @(negedge clk_sys);
        checkOutput("bp_hold_req", port_req, exp_req);
        ackPorts(m); @(negedge clk_sys);
        expectIssue("bp_skid", 32'hC00A, 8'hB2, m);
        ackPorts(m); repeat (2) @(negedge clk_sys);
        checkOutput("bp_dropped", port_req, exp_req);

        // Ack completion and a new accept in the same cycle.
        applyStimulus(32'h0020, 8'h55);
        expectIssue("sim_a", 32'h0020, 8'h55, m);
        @(negedge clk_sys);
        ackPorts(m);
        ioctl_addr = IO_AW'(32'h0031); ioctl_dout = 8'h66; ioctl_wr = 1'b1;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        expectIssue("sim_b", 32'h0031, 8'h66, m);
        ackPorts(m); repeat (3) @(negedge clk_sys);
        checkOutput("sim_skid_empty", port_req, exp_req);

        // Randomized windows, data and ack timing.
        for (int i = 0; i < 24; i++) begin
            addr = $urandom_range(0, 32'h1FFFF);
            data = 8'($urandom);
            applyStimulus(addr, data);
            expectIssue("rand", addr, data, m);
            repeat ($urandom_range(0, 3)) @(negedge clk_sys);
            ackPorts(m & 2'b01);
            repeat ($urandom_range(0, 3)) @(negedge clk_sys);
            checkOutput("rand_stable", port_req, exp_req);
            ackPorts(m);
            @(negedge clk_sys);
        end

        // Download ends with a request still outstanding.
        applyStimulus(32'h0040, 8'h77);
        expectIssue("late", 32'h0040, 8'h77, m);
        ioctl_download = 1'b0;
        repeat (3) @(negedge clk_sys);
        checkOutput("late_not_loaded", rom_loaded, 0);
        checkOutput("we_low", port_we, 0);
        ackPorts(m);
        cnt = 0;
        while (!rom_loaded && cnt < 10) begin @(negedge clk_sys); cnt++; end
        checkOutput("loaded_rise", rom_loaded, 1);
        cnt = 0;
        while (cnt < 40) begin
            @(negedge clk_sys); cnt++;
            if (!reset_out) break;
        end
        checkOutput("reset_hold_cycles", cnt, 17);
        rst_req = 1'b1;
        @(negedge clk_sys);
        checkOutput("rst_req_raise", reset_out, 1);
        rst_req = 1'b0;

        // New download with bytes outside every window.
        @(negedge clk_sys);
        ioctl_download = 1'b1;
        applyStimulus(32'h100000, 8'hFF);
        applyStimulus(32'h100001, 8'h01);
        applyStimulus(32'h100002, 8'h10);
        checkOutput("nohit_req", port_req, exp_req);
        checkOutput("loaded_sticky", rom_loaded, 1);
`ifdef ROM_ROUTER_CHECKSUM_EN
        checkOutput("checksum", checksum, 16'h0110);
`endif

        // Asynchronous reset while a request is outstanding.
        applyStimulus(32'h0002, 8'h99);
        expectIssue("pre_reset", 32'h0002, 8'h99, m);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("areset_req", port_req, 0);
        checkOutput("areset_a", port_a, 0);
        checkOutput("areset_ds", port_ds, 0);
        checkOutput("areset_d", port_d, 0);
        checkOutput("areset_we", port_we, 0);
        checkOutput("areset_loaded", rom_loaded, 0);
        checkOutput("areset_reset_out", reset_out, 1);
        checkOutput("areset_overflow", overflow, 0);
`ifdef ROM_ROUTER_CHECKSUM_EN
        checkOutput("areset_checksum", checksum, 0);
`endif
        exp_req = '0; port_ack = '0;

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
